m_mem_ctrl: RTL and testbench
=============================

M_MEM_CTRL -- requirements
Module: m_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the maximum REQ-state cycles to wait for bus_ack.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, M-stage memory instruction present; held with its operands stable while stall=1.
REQ-005 SHALL have port req_op, input, 3, operation: 0 LW, 1 LH, 2 LB, 3 SW, 4 SH, 5 SB, 6 LHU, 7 LBU.
REQ-006 SHALL have port req_addr, input, 32, byte address; port req_wdata, input, 32, store data, right-aligned.
REQ-007 SHALL have port stall, output, 1, freeze the pipeline at M stage.
REQ-008 SHALL have port rdata, output, 32, extended load result; port rdata_valid, output, 1, rdata is valid this cycle.
REQ-009 SHALL have port addr_exc, output, 1, misaligned-access pulse; port bus_err, output, 1, timeout pulse.
REQ-010 SHALL have port bus_req, output, 1; bus_addr, output, 32; bus_wdata, output, 32; bus_byteen, output, 4 (nonzero = write, 0000 = read).
REQ-011 SHALL have port bus_ack, input, 1, transfer complete; bus_rdata, input, 32, word read data, valid with bus_ack.

Function
REQ-012 SHALL implement the states IDLE, REQ, DONE and ERR.
REQ-013 SHALL define misaligned as: word op with addr[1:0]!=0, or halfword op with addr[0]=1; byte ops are never misaligned.
REQ-014 IDLE, req_valid=1 and aligned: SHALL assert stall combinationally in the same cycle, latch op, addr and wdata, clear the timeout counter, and enter REQ.
REQ-015 IDLE, req_valid=1 and misaligned: SHALL pulse addr_exc for that cycle, keep stall=0, issue no bus cycle, and remain in IDLE.
REQ-016 REQ: SHALL hold bus_req=1 and stall=1; bus_addr = latched address with [1:0] forced to 00.
REQ-017 REQ stores: SHALL drive bus_wdata = wdata << (8*addr[1:0]), and bus_byteen = 1111 for SW, 0011<<addr[1:0] for SH, 0001<<addr[1:0] for SB.
REQ-018 REQ loads: SHALL drive bus_byteen = 0000 and bus_wdata = 0.
REQ-019 REQ with bus_ack=1: SHALL capture bus_rdata and enter DONE next cycle; bus_req SHALL drop in the cycle after the ack.
REQ-020 REQ with bus_ack=0: SHALL increment the counter; when the counter reaches TIMEOUT, SHALL enter ERR instead. bus_ack in the same cycle as the limit wins and enters DONE.
REQ-021 DONE: SHALL set stall=0, set rdata_valid=1 for loads and 0 for stores, and return to IDLE; the pipeline advances this cycle and req_valid is ignored.
REQ-022 rdata extraction: SHALL select the lane as word>>(8*addr[1:0]); LW passes the word; LH/LB sign-extend bits 15/7; LHU/LBU zero-extend; rdata=0 when rdata_valid=0.
REQ-023 ERR: SHALL pulse bus_err for one cycle with stall=0 and rdata_valid=0, then return to IDLE.
REQ-024 Latency: with the request accepted at cycle 0 and the ack at cycle k≥1 (bus_req high cycles 1..k), DONE SHALL occur at cycle k+1; minimum 3-cycle occupancy.
REQ-025 Outputs outside the states that drive them SHALL be 0: bus_* outside REQ, rdata_valid outside DONE, pulses otherwise.
REQ-026 bus_ack received outside REQ SHALL be ignored.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for clk, force IDLE with counter=0 and all latched fields 0.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset in REQ SHALL drop bus_req within the same cycle, abandon the transfer, and produce no rdata_valid, bus_err or retry.

Verification
REQ-030 SW, addr 0x104, wdata 0x11223344, ack on 2nd REQ cycle -> bus_req for 2 cycles; bus_addr 0x104; byteen 1111; DONE at cycle 3; rdata_valid 0.
REQ-031 SB, addr 0x0203, wdata 0x000000AB -> bus_wdata 0xAB000000, byteen 1000; LB at the same address with bus_rdata 0x80FFFFFF -> rdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-032 LH, addr 0x0102, bus_rdata 0x8001_7FFF -> rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-033 LW at addr 0x0101, then SH at 0x0003 -> addr_exc pulse each, stall 0, bus_req never asserted.
REQ-034 TIMEOUT=15, LW, no ack -> bus_req 15 cycles, bus_err one pulse, stall drops, IDLE; a later ack is ignored.
REQ-035 Assert reset on the 2nd REQ cycle -> bus_req low the same cycle; after release, the next LW completes normally.

Source files
------------

// File: rtl/m_mem_ctrl.sv
// Memory-stage load/store controller: aligns byte/half/word accesses onto a
// 32-bit request/ack bus, extends load data, and flags misalignment and bus timeouts.
module m_mem_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_exc,
    output logic        bus_err,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_e;
    typedef enum logic [2:0] {
        OP_LW, OP_LH, OP_LB, OP_SW, OP_SH, OP_SB, OP_LHU, OP_LBU
    } op_e;

    // Counter only has to reach TIMEOUT-1: the limit is detected one cycle early.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    op_e         in_op;
    logic        misaligned;
    logic        is_store;
    logic [31:0] lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_op = op_e'(req_op);
        case (in_op)
            OP_LW, OP_SW:         misaligned = |req_addr[1:0];
            OP_LH, OP_SH, OP_LHU: misaligned = req_addr[0];
            default:              misaligned = 1'b0;
        endcase
        is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
        lane     = data_q >> {addr_q[1:0], 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        rdata       = '0;
        rdata_valid = 1'b0;
        addr_exc    = 1'b0;
        bus_err     = 1'b0;
        bus_req     = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_byteen  = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        addr_exc = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        op_d    = in_op;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall    = 1'b1;
                bus_req  = 1'b1;
                bus_addr = {addr_q[31:2], 2'b00};
                if (is_store) begin
                    bus_wdata = wdata_q << {addr_q[1:0], 3'b000};
                    case (op_q)
                        OP_SW:   bus_byteen = 4'b1111;
                        OP_SH:   bus_byteen = 4'b0011 << addr_q[1:0];
                        default: bus_byteen = 4'b0001 << addr_q[1:0];
                    endcase
                end
                if (bus_ack) begin
                    data_d  = bus_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (!is_store) begin
                    rdata_valid = 1'b1;
                    case (op_q)
                        OP_LH:   rdata = {{16{lane[15]}}, lane[15:0]};
                        OP_LB:   rdata = {{24{lane[7]}}, lane[7:0]};
                        OP_LHU:  rdata = {16'h0000, lane[15:0]};
                        OP_LBU:  rdata = {24'h000000, lane[7:0]};
                        default: rdata = data_q;
                    endcase
                end
                state_d = S_IDLE;
            end
            default: begin
                bus_err = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Reset forces IDLE asynchronously, but IDLE still decodes req_valid, so gate here.
        if (reset) begin
            stall    = 1'b0;
            addr_exc = 1'b0;
        end
    end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Self-checking bench for m_mem_ctrl: directed vector table, reset corner case,
// and randomized transactions against a byte-lane reference model.
module tb_m_mem_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_exc;
    logic        bus_err;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_chk = 0;
    int n_fail = 0;

    m_mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .addr_exc(addr_exc),
        .bus_err(bus_err), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_k;
        logic [31:0] rword;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_bw;
        logic        exp_exc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0, 3'd3:       return 4;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return (op >= 3'd3) && (op <= 3'd5);
    endfunction

    function automatic bit op_signed(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd2);
    endfunction

    // Reference model: works on individual bytes and plain integer arithmetic.
    function automatic bit m_misaligned(input logic [2:0] op, input logic [31:0] addr);
        return (addr % op_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_byteen(input logic [2:0] op, input logic [31:0] addr);
        logic [3:0] be = '0;
        if (op_store(op))
            for (int j = 0; j < op_size(op); j++) be[int'(addr % 4) + j] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_bwdata(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] wd);
        logic [31:0] r = '0;
        int a = int'(addr % 4);
        if (op_store(op))
            for (int j = 0; j < 4 - a; j++) r[8*(a+j) +: 8] = wd[8*j +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] word);
        longint v = 0;
        int a = int'(addr % 4);
        int sz = op_size(op);
        if (op_store(op)) return '0;
        for (int j = 0; j < sz; j++) v += longint'(word[8*(a+j) +: 8]) << (8*j);
        if (op_signed(op) && v >= (longint'(1) << (8*sz - 1))) v -= longint'(1) << (8*sz);
        return v[31:0];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
        chk({tag, ".bus_req"}, {31'd0, bus_req}, 32'd0);
        chk({tag, ".rvalid"}, {31'd0, rdata_valid}, 32'd0);
        chk({tag, ".bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({tag, ".addr_exc"}, {31'd0, addr_exc}, 32'd0);
    endtask

    // Starts just after a rising edge; every check is made at the falling edge.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_k, input logic [31:0] rword, input logic [31:0] exp_rd,
                          input logic [3:0] exp_be, input logic [31:0] exp_bw,
                          input logic exp_exc, input logic late_ack);
        bit tmo = (ack_k == 0) || (ack_k > TO);
        int nreq = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; bus_ack = 1'b0;
        @(negedge clk);
        chk("acc.addr_exc", {31'd0, addr_exc}, {31'd0, exp_exc});
        chk("acc.stall", {31'd0, stall}, {31'd0, !exp_exc});
        chk("acc.bus_req", {31'd0, bus_req}, 32'd0);
        if (!exp_exc) begin
            for (int c = 1; c <= TO; c++) begin
                @(posedge clk); #1;
                bus_ack = (c == ack_k);
                bus_rdata = (c == ack_k) ? rword : $urandom;
                @(negedge clk);
                nreq += int'(bus_req);
                chk("req.stall", {31'd0, stall}, 32'd1);
                chk("req.bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("req.byteen", {28'd0, bus_byteen}, {28'd0, exp_be});
                chk("req.bus_wdata", bus_wdata, exp_bw);
                chk("req.rvalid", {31'd0, rdata_valid}, 32'd0);
                if (c == ack_k) break;
            end
            chk("req.cycles", nreq, tmo ? TO : ack_k);
            @(posedge clk); #1;
            bus_ack = late_ack;
            bus_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            chk("end.stall", {31'd0, stall}, 32'd0);
            chk("end.bus_req", {31'd0, bus_req}, 32'd0);
            chk("end.bus_err", {31'd0, bus_err}, {31'd0, tmo});
            chk("end.rvalid", {31'd0, rdata_valid}, {31'd0, !tmo && !op_store(op)});
            chk("end.rdata", rdata, tmo ? 32'd0 : exp_rd);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk_idle("idle");
        bus_ack = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{3'd3, 32'h0000_0104, 32'h1122_3344, 2, 32'h0, 32'h0, 4'b1111, 32'h1122_3344, 1'b0},
            '{3'd5, 32'h0000_0203, 32'h0000_00AB, 1, 32'h0, 32'h0, 4'b1000, 32'hAB00_0000, 1'b0},
            '{3'd2, 32'h0000_0203, 32'h0, 1, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b0000, 32'h0, 1'b0},
            '{3'd7, 32'h0000_0203, 32'h0, 3, 32'h80FF_FFFF, 32'h0000_0080, 4'b0000, 32'h0, 1'b0},
            '{3'd1, 32'h0000_0102, 32'h0, 3, 32'h8001_7FFF, 32'hFFFF_8001, 4'b0000, 32'h0, 1'b0},
            '{3'd6, 32'h0000_0102, 32'h0, 1, 32'h8001_7FFF, 32'h0000_8001, 4'b0000, 32'h0, 1'b0},
            '{3'd0, 32'h0000_0101, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1},
            '{3'd4, 32'h0000_0003, 32'h5555, 1, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b1},
            '{3'd0, 32'h0000_0200, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0},
            '{3'd0, 32'h0000_0300, 32'h0, TO, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'h0, 1'b0},
            '{3'd4, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h0, 32'h0, 4'b1100, 32'hABCD_0000, 1'b0},
            '{3'd2, 32'h0000_0040, 32'h0, 2, 32'h1234_567F, 32'h0000_007F, 4'b0000, 32'h0, 1'b0}
        };

        reset = 1'b1; req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h100;
        req_wdata = '0; bus_ack = 1'b1; bus_rdata = '0;
        #2;
        chk_idle("rst");
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.byteen", {28'd0, bus_byteen}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; bus_ack = 1'b0;

        foreach (vecs[i])
            do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].ack_k, vecs[i].rword,
                   vecs[i].exp_rdata, vecs[i].exp_be, vecs[i].exp_bw, vecs[i].exp_exc,
                   vecs[i].ack_k == 0);

        // Reset asserted in the middle of the second REQ cycle abandons the transfer.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rreq.bus_req", {31'd0, bus_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rreq.bus_req_drop", {31'd0, bus_req}, 32'd0);
        chk("rreq.stall", {31'd0, stall}, 32'd0);
        chk("rreq.bus_addr", bus_addr, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_idle("rpost");
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        do_txn(3'd0, 32'h0000_0400, 32'h0, 2, 32'hCAFE_F00D, 32'hCAFE_F00D,
               4'b0000, 32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] ad = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rw = $urandom;
            int          k  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            do_txn(op, ad, wd, k, rw, m_rdata(op, ad, rw), m_byteen(op, ad),
                   m_bwdata(op, ad, wd), m_misaligned(op, ad), k == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
